// File: rtl/execute_stage_if.sv
// Decode-to-execute bus for the RV32IM execute stage.
// master: decode/hazard side; drives en_E and the *_D instruction fields,
//         and receives the E-stage results, redirect and busy_E.
// slave : execute_stage; receives the *_D fields, drives the E-stage outputs.
interface execute_stage_if #(
  parameter int XLEN = 32
);
  logic            en_E;
  logic            valid_D;
  logic [XLEN-1:0] pc_D;
  logic [XLEN-1:0] rs1_data_D;
  logic [XLEN-1:0] rs2_data_D;
  logic [XLEN-1:0] imm_D;
  logic [3:0]      alu_op_D;
  logic            alu_src_D;
  logic            br_en_D;
  logic [2:0]      br_type_D;
  logic            jal_D;
  logic            jalr_D;
  logic            mul_D;
  logic [1:0]      mul_op_D;
  logic            reg_WE_D;
  logic [4:0]      rs3_D;

  logic [XLEN-1:0] alu_out_E;
  logic [XLEN-1:0] store_data_E;
  logic [4:0]      rs3_E;
  logic            reg_WE_E;
  logic            jumping;
  logic [XLEN-1:0] jump_target;
  logic            busy_E;

  modport master (
    output en_E, valid_D, pc_D, rs1_data_D, rs2_data_D, imm_D, alu_op_D,
           alu_src_D, br_en_D, br_type_D, jal_D, jalr_D, mul_D, mul_op_D,
           reg_WE_D, rs3_D,
    input  alu_out_E, store_data_E, rs3_E, reg_WE_E, jumping, jump_target,
           busy_E
  );

  modport slave (
    input  en_E, valid_D, pc_D, rs1_data_D, rs2_data_D, imm_D, alu_op_D,
           alu_src_D, br_en_D, br_type_D, jal_D, jalr_D, mul_D, mul_op_D,
           reg_WE_D, rs3_D,
    output alu_out_E, store_data_E, rs3_E, reg_WE_E, jumping, jump_target,
           busy_E
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the RV32IM pipeline: D->E register, ALU, branch/jump
// resolution and a 32-cycle shift-add multiplier.
// Ports:
//   clk     - clock, all state on rising edge
//   reset_E - async active-high reset (global reset OR flush_E)
//   bus     - execute_stage_if.slave: *_D instruction fields and en_E in;
//             alu_out_E, store_data_E, rs3_E, reg_WE_E, jumping,
//             jump_target, busy_E out
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_E,
  execute_stage_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mstate_t;
  mstate_t state_q, state_d;

  logic            busy;
  logic            load;
  logic            mul_start;

  // D->E pipeline register
  logic            valid_q, alu_src_q, br_en_q, jal_q, jalr_q, mul_q, reg_we_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [3:0]      alu_op_q;
  logic [2:0]      br_type_q;
  logic [1:0]      mul_op_q;
  logic [4:0]      rs3_q;

  // multiplier datapath
  logic [2*XLEN-1:0] mcand_q, acc_q, prod;
  logic [XLEN-1:0]   mplier_q, mul_res;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;

  logic [XLEN-1:0] op_b, alu_res;
  logic [CW-1:0]   shamt;
  logic            cond;

  assign load      = bus.en_E & ~busy;
  assign mul_start = bus.valid_D & bus.mul_D;

  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      br_en_q   <= 1'b0;
      br_type_q <= '0;
      jal_q     <= 1'b0;
      jalr_q    <= 1'b0;
      mul_q     <= 1'b0;
      mul_op_q  <= '0;
      reg_we_q  <= 1'b0;
      rs3_q     <= '0;
    end else if (load) begin
      valid_q   <= bus.valid_D;
      pc_q      <= bus.pc_D;
      rs1_q     <= bus.rs1_data_D;
      rs2_q     <= bus.rs2_data_D;
      imm_q     <= bus.imm_D;
      alu_op_q  <= bus.alu_op_D;
      alu_src_q <= bus.alu_src_D;
      br_en_q   <= bus.br_en_D;
      br_type_q <= bus.br_type_D;
      jal_q     <= bus.jal_D;
      jalr_q    <= bus.jalr_D;
      mul_q     <= bus.mul_D;
      mul_op_q  <= bus.mul_op_D;
      reg_we_q  <= bus.reg_WE_D;
      rs3_q     <= bus.rs3_D;
    end
  end

  // Operands are made magnitude-only at load; the sign is restored on the
  // 64-bit product so one unsigned shift-add loop covers all four ops.
  always_comb begin
    a_neg = bus.rs1_data_D[XLEN-1] & ((bus.mul_op_D == 2'd1) | (bus.mul_op_D == 2'd2));
    b_neg = bus.rs2_data_D[XLEN-1] & (bus.mul_op_D == 2'd1);
    a_abs = a_neg ? -bus.rs1_data_D : bus.rs1_data_D;
    b_abs = b_neg ? -bus.rs2_data_D : bus.rs2_data_D;
  end

  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else if (load && mul_start) begin
      mcand_q  <= {{XLEN{1'b0}}, a_abs};
      mplier_q <= b_abs;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= a_neg ^ b_neg;
    end else if (state_q == S_BUSY) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load && mul_start) state_d = S_BUSY;
      S_BUSY: if (cnt_q == CW'(XLEN-1)) state_d = S_DONE;
      S_DONE: if (load) state_d = mul_start ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_BUSY);
  end

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    mul_res = (mul_op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    op_b  = alu_src_q ? imm_q : rs2_q;
    shamt = op_b[CW-1:0];
    case (alu_op_q)
      4'd0:    alu_res = rs1_q + op_b;
      4'd1:    alu_res = rs1_q - op_b;
      4'd2:    alu_res = rs1_q << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_q) < $signed(op_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, rs1_q < op_b};
      4'd5:    alu_res = rs1_q ^ op_b;
      4'd6:    alu_res = rs1_q >> shamt;
      4'd7:    alu_res = $signed(rs1_q) >>> shamt;
      4'd8:    alu_res = rs1_q | op_b;
      4'd9:    alu_res = rs1_q & op_b;
      4'd10:   alu_res = op_b;
      4'd11:   alu_res = pc_q + imm_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (br_type_q)
      3'd0:    cond = (rs1_q == rs2_q);
      3'd1:    cond = (rs1_q != rs2_q);
      3'd4:    cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'd5:    cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'd6:    cond = (rs1_q <  rs2_q);
      3'd7:    cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign bus.alu_out_E    = (jal_q | jalr_q) ? pc_q + XLEN'(4) :
                            mul_q            ? mul_res : alu_res;
  assign bus.store_data_E = rs2_q;
  assign bus.rs3_E        = rs3_q;
  assign bus.reg_WE_E     = reg_we_q & valid_q & (rs3_q != 5'd0);
  assign bus.jumping      = valid_q & ~mul_q & (jal_q | jalr_q | (br_en_q & cond));
  assign bus.jump_target  = jalr_q ? ((rs1_q + imm_q) & ~XLEN'(1)) : pc_q + imm_q;
  assign bus.busy_E       = busy;
endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  logic clk;
  logic reset_E;
  execute_stage_if #(.XLEN(32)) bus ();

  execute_stage #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_E (reset_E),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0]  op;
    logic        src, br_en;
    logic [2:0]  bt;
    logic        jal, jalr, mul;
    logic [1:0]  mop;
    logic        we;
    logic [4:0]  rs3;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    bit          chk_alu;
    logic        jmp;
    logic [31:0] tgt;
    bit          chk_tgt;
    logic        we;
    int          busy_cyc;
    int          holds;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = '{valid: 1'b1, pc: 32'h100, rs1: a, rs2: b, imm: 32'h0, op: op, src: 1'b0,
          br_en: 1'b0, bt: 3'd2, jal: 1'b0, jalr: 1'b0, mul: 1'b0, mop: 2'd0,
          we: 1'b1, rs3: 5'd5};
    return i;
  endfunction

  function automatic instr_t mkmul(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = mk(4'd0, a, b);
    i.mul = 1'b1;
    i.mop = mop;
    return i;
  endfunction

  function automatic exp_t ex(input logic [31:0] alu, input bit ca, input logic jmp,
                              input logic [31:0] tgt, input bit ct, input logic we,
                              input int bc, input int holds);
    exp_t e;
    e = '{alu: alu, chk_alu: ca, jmp: jmp, tgt: tgt, chk_tgt: ct, we: we,
          busy_cyc: bc, holds: holds};
    return e;
  endfunction

  task automatic drive(input instr_t i);
    bus.valid_D    = i.valid;
    bus.pc_D       = i.pc;
    bus.rs1_data_D = i.rs1;
    bus.rs2_data_D = i.rs2;
    bus.imm_D      = i.imm;
    bus.alu_op_D   = i.op;
    bus.alu_src_D  = i.src;
    bus.br_en_D    = i.br_en;
    bus.br_type_D  = i.bt;
    bus.jal_D      = i.jal;
    bus.jalr_D     = i.jalr;
    bus.mul_D      = i.mul;
    bus.mul_op_D   = i.mop;
    bus.reg_WE_D   = i.we;
    bus.rs3_D      = i.rs3;
  endtask

  task automatic expect_out(input string nm, input exp_t e);
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_E && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy_E) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout: busy_E still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // Drives one instruction for a single load edge, then stalls until idle.
  task automatic issue(input string nm, input instr_t i, input exp_t e);
    drive(i);
    expect_out(nm, e);
    bus.en_E = 1'b1;
    @(posedge clk); #1;
    bus.en_E = 1'b0;
    wait_idle();
  endtask

  task automatic compare_out(input string nm, input exp_t e);
    if (e.chk_alu) chk({nm, " alu_out_E"}, bus.alu_out_E, e.alu);
    chk({nm, " jumping"}, {31'b0, bus.jumping}, {31'b0, e.jmp});
    if (e.chk_tgt) chk({nm, " jump_target"}, bus.jump_target, e.tgt);
    chk({nm, " reg_WE_E"}, {31'b0, bus.reg_WE_E}, {31'b0, e.we});
  endtask

  // Monitor: an instruction is presented on the first non-busy negedge after
  // the edge that loaded it; the expected response is popped at that point.
  initial begin : monitor
    bit    load_prev = 0;
    bit    pending   = 0;
    int    bcnt      = 0;
    int    hold_left = 0;
    exp_t  cur;
    string cur_nm;
    forever begin
      @(negedge clk);
      if (reset_E) begin
        load_prev = 0; pending = 0; hold_left = 0;
        continue;
      end
      if (hold_left > 0) begin
        compare_out({cur_nm, " hold"}, cur);
        hold_left--;
      end
      if (load_prev) begin
        pending = 1; bcnt = 0;
      end
      if (pending) begin
        if (bus.busy_E) begin
          bcnt++;
          if (bcnt > 40) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: busy_E high %0d cycles, expected at most 32", bcnt);
            pending = 0;
          end
        end else begin
          pending = 0;
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: 1 unexpected presentation, expected 0");
          end else begin
            cur    = sb.pop_front();
            cur_nm = sb_name.pop_front();
            chk({cur_nm, " busy cycles"}, 32'(bcnt), 32'(cur.busy_cyc));
            compare_out(cur_nm, cur);
            hold_left = cur.holds;
          end
        end
      end
      load_prev = bus.en_E && !bus.busy_E;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    instr_t i;
    reset_E = 1'b1;
    bus.en_E = 1'b0;
    drive(mk(4'd0, 32'h0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset alu_out_E",    bus.alu_out_E, 32'h0);
    chk("reset store_data_E", bus.store_data_E, 32'h0);
    chk("reset rs3_E",        {27'b0, bus.rs3_E}, 32'h0);
    chk("reset reg_WE_E",     {31'b0, bus.reg_WE_E}, 32'h0);
    chk("reset jumping",      {31'b0, bus.jumping}, 32'h0);
    chk("reset jump_target",  bus.jump_target, 32'h0);
    chk("reset busy_E",       {31'b0, bus.busy_E}, 32'h0);
    reset_E = 1'b0;

    // Reset in the middle of a multiply: abandoned, no result presented.
    drive(mkmul(2'd0, 32'd7, 32'd6));
    bus.en_E = 1'b1;
    @(posedge clk); #1;
    bus.en_E = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset_E = 1'b1;
    #1;
    chk("midmul busy_E",       {31'b0, bus.busy_E}, 32'h0);
    chk("midmul alu_out_E",    bus.alu_out_E, 32'h0);
    chk("midmul store_data_E", bus.store_data_E, 32'h0);
    chk("midmul rs3_E",        {27'b0, bus.rs3_E}, 32'h0);
    chk("midmul reg_WE_E",     {31'b0, bus.reg_WE_E}, 32'h0);
    chk("midmul jumping",      {31'b0, bus.jumping}, 32'h0);
    chk("midmul jump_target",  bus.jump_target, 32'h0);
    #4 reset_E = 1'b0;
    @(posedge clk); #1;
    issue("post-reset ADD", mk(4'd0, 32'd1, 32'd2), ex(32'd3, 1, 0, 0, 0, 1, 0, 0));
    chk("post-reset store_data_E", bus.store_data_E, 32'd2);
    chk("post-reset rs3_E", {27'b0, bus.rs3_E}, 32'd5);

    // ALU sweep, A=0x8000_0000, B=4
    issue("ADD",   mk(4'd0,  32'h8000_0000, 32'd4), ex(32'h8000_0004, 1, 0, 0, 0, 1, 0, 0));
    issue("SUB",   mk(4'd1,  32'h8000_0000, 32'd4), ex(32'h7FFF_FFFC, 1, 0, 0, 0, 1, 0, 0));
    issue("SLL",   mk(4'd2,  32'h8000_0000, 32'd4), ex(32'h0000_0000, 1, 0, 0, 0, 1, 0, 0));
    issue("SLT",   mk(4'd3,  32'h8000_0000, 32'd4), ex(32'h0000_0001, 1, 0, 0, 0, 1, 0, 0));
    issue("SLTU",  mk(4'd4,  32'h8000_0000, 32'd4), ex(32'h0000_0000, 1, 0, 0, 0, 1, 0, 0));
    issue("XOR",   mk(4'd5,  32'h8000_0000, 32'd4), ex(32'h8000_0004, 1, 0, 0, 0, 1, 0, 0));
    issue("SRL",   mk(4'd6,  32'h8000_0000, 32'd4), ex(32'h0800_0000, 1, 0, 0, 0, 1, 0, 0));
    issue("SRA",   mk(4'd7,  32'h8000_0000, 32'd4), ex(32'hF800_0000, 1, 0, 0, 0, 1, 0, 0));
    issue("OR",    mk(4'd8,  32'h8000_0000, 32'd4), ex(32'h8000_0004, 1, 0, 0, 0, 1, 0, 0));
    issue("AND",   mk(4'd9,  32'h8000_0000, 32'd4), ex(32'h0000_0000, 1, 0, 0, 0, 1, 0, 0));
    issue("PASSB", mk(4'd10, 32'h8000_0000, 32'd4), ex(32'h0000_0004, 1, 0, 0, 0, 1, 0, 0));
    issue("OP12",  mk(4'd12, 32'h8000_0000, 32'd4), ex(32'h0000_0000, 1, 0, 0, 0, 1, 0, 0));
    i = mk(4'd7, 32'h8000_0000, 32'd4); i.imm = 32'h0000_0024; i.src = 1'b1;  // shamt from imm[4:0]=4
    issue("SRA imm", i, ex(32'hF800_0000, 1, 0, 0, 0, 1, 0, 0));
    i = mk(4'd11, 32'h0, 32'h0); i.pc = 32'h100; i.imm = 32'h1000;
    issue("AUIPC", i, ex(32'h0000_1100, 1, 0, 0, 0, 1, 0, 0));

    // Branches and jumps
    i = mk(4'd0, 32'hFFFF_FFFF, 32'd1); i.pc = 32'h200; i.imm = 32'h40; i.br_en = 1; i.bt = 3'd4; i.we = 0;
    issue("BLT", i, ex(0, 0, 1, 32'h240, 1, 0, 0, 0));
    i.bt = 3'd6;
    issue("BLTU", i, ex(0, 0, 0, 32'h240, 1, 0, 0, 0));
    i.bt = 3'd5;
    issue("BGE", i, ex(0, 0, 0, 32'h240, 1, 0, 0, 0));
    i.bt = 3'd1;
    issue("BNE", i, ex(0, 0, 1, 32'h240, 1, 0, 0, 0));
    i.rs2 = 32'hFFFF_FFFF; i.bt = 3'd2;
    issue("BR type2", i, ex(0, 0, 0, 32'h240, 1, 0, 0, 0));
    i.bt = 3'd0;
    issue("BEQ", i, ex(0, 0, 1, 32'h240, 1, 0, 0, 0));
    i.valid = 1'b0;
    issue("BEQ invalid", i, ex(0, 0, 0, 32'h240, 1, 0, 0, 0));
    i = mk(4'd0, 32'h203, 32'h0); i.pc = 32'h300; i.jalr = 1;
    issue("JALR", i, ex(32'h304, 1, 1, 32'h202, 1, 1, 0, 0));
    i = mk(4'd0, 32'h0, 32'h0); i.pc = 32'h400; i.imm = 32'h20; i.jal = 1;
    issue("JAL", i, ex(32'h404, 1, 1, 32'h420, 1, 1, 0, 0));

    // Multiply
    issue("MULH",   mkmul(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), ex(32'h0000_0000, 1, 0, 0, 0, 1, 32, 0));
    issue("MULHU",  mkmul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), ex(32'hFFFF_FFFE, 1, 0, 0, 0, 1, 32, 0));
    issue("MUL",    mkmul(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), ex(32'h0000_0001, 1, 0, 0, 0, 1, 32, 0));
    issue("MULHSU", mkmul(2'd2, 32'hFFFF_FFFE, 32'd3),        ex(32'hFFFF_FFFF, 1, 0, 0, 0, 1, 32, 0));
    issue("MUL 7x6", mkmul(2'd0, 32'd7, 32'd6),               ex(32'd42, 1, 0, 0, 0, 1, 32, 0));

    // Stall: result holds for 5 cycles with en_E=0
    issue("XOR stall", mk(4'd5, 32'hF0, 32'hFF), ex(32'h0F, 1, 0, 0, 0, 1, 0, 5));
    repeat (5) @(posedge clk);
    #1;

    // en_E held high while busy: the ADD waits until the multiply is done
    drive(mkmul(2'd0, 32'd3, 32'd5));
    expect_out("MUL en held", ex(32'd15, 1, 0, 0, 0, 1, 32, 0));
    bus.en_E = 1'b1;
    @(posedge clk); #1;
    drive(mk(4'd0, 32'd10, 32'd20));
    expect_out("ADD after MUL", ex(32'd30, 1, 0, 0, 0, 1, 0, 0));
    wait_idle();
    @(posedge clk); #1;
    bus.en_E = 1'b0;

    // Write-enable gating
    i = mk(4'd0, 32'd1, 32'd1); i.rs3 = 5'd0;
    issue("WE rd0", i, ex(32'd2, 1, 0, 0, 0, 0, 0, 0));
    i = mk(4'd0, 32'd1, 32'd1); i.valid = 1'b0;
    issue("WE invalid", i, ex(32'd2, 1, 0, 0, 0, 0, 0, 0));
    i = mk(4'd0, 32'd1, 32'd1); i.rs3 = 5'd31;
    issue("WE rd31", i, ex(32'd2, 1, 0, 0, 0, 1, 0, 0));

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32IM pipeline, between decode and the memory-stage register. It contains:
- the D→E pipeline register;
- the RV32I ALU;
- branch/jump resolution, which drives `jumping` and `jump_target` back to fetch and to the hazard logic;
- a 32-cycle iterative multiplier, whose `busy_E` output the hazard logic uses to stall F/D/E.

Flushes arrive through `reset_E`, which upstream drives as global reset OR flush_E.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_E  in  1  reset reset_E, asynchronous, active-high (global reset OR flush_E)
- en_E  in  1  stage enable (= ~stall_E); loads D→E register when high and busy_E low
- valid_D  in  1  decode slot holds a real instruction
- pc_D  in  32  instruction PC
- rs1_data_D, rs2_data_D  in  32  operand values
- imm_D  in  32  sign-extended immediate
- alu_op_D  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 AUIPC; 12–15 result 0
- alu_src_D  in  1  0: B=rs2_data, 1: B=imm
- br_en_D  in  1  conditional branch
- br_type_D  in  3  funct3 encoding: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2/3 never taken
- jal_D, jalr_D  in  1  unconditional jumps
- mul_D  in  1  M-extension multiply
- mul_op_D  in  2  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
- reg_WE_D  in  1  writes rd
- rs3_D  in  5  destination register
- alu_out_E  out  32  result to memory stage
- store_data_E  out  32  registered rs2_data
- rs3_E  out  5  registered destination
- reg_WE_E  out  1  registered write enable, gated by valid
- jumping  out  1  taken branch/jump in E this cycle
- jump_target  out  32  redirect PC
- busy_E  out  1  multiplier iterating

## Operation
- **Reset (async, any time).** reset_E clears all E registers to 0 and forces the multiplier FSM to IDLE.
  - Outputs go to 0: alu_out_E, store_data_E, rs3_E, reg_WE_E, jumping, jump_target, busy_E.
  - A multiply in progress is abandoned; no result is produced.
- **Load.** On a rising edge with en_E=1 and busy_E=0, all `*_D` inputs are captured into E. Otherwise E holds its contents; en_E is ignored while busy_E=1.
- **ALU inputs.** A = rs1_data_E; B per alu_src_E.
- **Shifts.** Amount = B[4:0].
- **Compares.** SLT/SLTU produce 0 or 1.
- **AUIPC.** Result is pc_E+imm_E.
- **Arithmetic width.** Wraps modulo 2^32.
- **Result select for alu_out_E:**
  - jal_E or jalr_E → pc_E+4;
  - mul_E → multiplier result;
  - otherwise → ALU result.
- **Branch resolution.**
  - taken = valid_E & (jal_E | jalr_E | (br_en_E & cond)).
  - cond is evaluated on rs1_data_E vs rs2_data_E, signed or unsigned per br_type.
  - jumping = taken (combinational from E registers).
- **jump_target.**
  - jalr_E → (rs1_data_E+imm_E) & ~1;
  - otherwise → pc_E+imm_E.
- **reg_WE_E** = reg_WE_E_reg & valid_E & (rs3_E≠0).
- **Multiplier FSM.** States IDLE, BUSY, DONE.
  - IDLE→BUSY when a load captures valid_D & mul_D.
    - The load edge latches |a| and |b| and the sign-fix flag.
    - It also clears the 64-bit accumulator and sets count=0.
    - Operand signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MUL/MULHU unsigned.
  - BUSY performs one shift-add per cycle. BUSY→DONE after count=31, giving 32 cycles in BUSY.
  - DONE holds the product. If the sign flag is set, the product is negated (two's complement, 64-bit).
    - MUL output = [31:0]; the other ops output [63:32].
  - DONE→IDLE on the next load. A load of another mul goes directly to BUSY.
  - busy_E = (state==BUSY).
- **Output validity during a multiply.**
  - alu_out_E is undefined while busy_E=1.
  - jumping=0 for mul instructions.

## Timing
- **Non-mul instructions.** Captured at edge N; alu_out_E, jumping and jump_target are valid combinationally during cycle N→N+1. Latency is 1 cycle.
- **Mul.**
  - Captured at edge N; busy_E=1 from edge N to edge N+32.
  - DONE from edge N+32; alu_out_E is valid in that cycle.
  - The earliest next load is edge N+33.
- **Stall.** While en_E=0 and not busy, every output holds its value indefinitely.
- **Simultaneous reset_E and load edge.** Reset wins; the E stage is empty afterwards.
- **Reset vs busy_E.** reset_E asserted during BUSY drops busy_E asynchronously in the same cycle.
- **Redirect.** jumping is asserted for exactly the one cycle the instruction sits in E, provided the upstream flush clears E on the next edge.

## Test plan
- **Reset mid-multiply.**
  - Stimulus: load MUL 7×6; assert reset_E at cycle 10.
  - Response: busy_E→0 immediately; all outputs 0; next ADD 1+2 yields alu_out_E=3 one cycle after load.
- **ALU sweep.**
  - Stimulus: A=0x8000_0000, B=4.
  - Response:
    - ADD→0x8000_0004
    - SUB→0x7FFF_FFFC
    - SRA→0xF800_0000
    - SRL→0x0800_0000
    - SLT→1
    - SLTU→0
  - Stimulus: AUIPC with pc=0x100, imm=0x1000. Response: 0x1100.
- **Branches.**
  - Stimulus: BLT with rs1=-1, rs2=1. Response: jumping=1, target=pc+imm.
  - Stimulus: BLTU with the same operands. Response: jumping=0.
  - Stimulus: JALR with rs1=0x203, imm=0. Response: target=0x202, alu_out_E=pc+4.
- **Multiply.**
  - Stimulus: MULH 0xFFFF_FFFF × 0xFFFF_FFFF. Response: busy_E high exactly 32 cycles, then alu_out_E=0.
  - Stimulus: MULHU on the same operands. Response: 0xFFFF_FFFE.
  - Stimulus: MUL on the same operands. Response: 1.
- **Stall/hold.**
  - Stimulus: en_E=0 for 5 cycles after loading XOR 0xF0^0xFF. Response: alu_out_E stays 0x0F.
  - Stimulus: en_E=1 while busy_E=1. Response: the load is ignored.
- **Write-enable gating.**
  - Stimulus: reg_WE_D=1 with rs3_D=0, or valid_D=0. Response: reg_WE_E=0.
